// File: rtl/ble_rx_queue.sv
// Buffers UART RX bytes in a FIFO and writes each one to RAM inside a circular word window.
// Latency: strobe -> count+1 next cycle -> cyc one cycle later (CPU idle); cyc drops on the cycle after ack.
// Backpressure: none toward uart_rx; a full FIFO drops the byte and sets sticky overflow. RAM side waits for ack.
module ble_rx_queue #(
    parameter int          BITS   = 8,
    parameter int          DEPTH  = 16,
    parameter logic [31:0] ADR_LL = 32'h730,
    parameter logic [31:0] ADR_UL = 32'h1FFC
) (
    input  logic                     i_wb_clk,
    input  logic                     i_wb_rst,
    input  logic [BITS-1:0]          i_rx_dat,
    input  logic                     i_rx_done,
    input  logic                     i_cpu_cyc,
    output logic [31:0]              o_wb_adr,
    output logic [31:0]              o_wb_dat,
    output logic [3:0]               o_wb_sel,
    output logic                     o_wb_we,
    output logic                     o_wb_cyc,
    input  logic                     i_wb_ack,
    output logic                     o_grant,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    // FIFO storage and bookkeeping
    logic [BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_idx_q;
    logic [AW-1:0]   rd_idx_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            ovf_q;
    logic            push;
    logic            pop;

    // Bus-side state
    state_t          state_q;
    state_t          state_d;
    logic            cyc_q;
    logic            cyc_d;
    logic [31:0]     adr_q;
    logic [31:0]     adr_d;
    logic [31:0]     dat_q;
    logic [31:0]     dat_d;
    logic [31:0]     ptr_q;
    logic [31:0]     ptr_d;

    // Fullness is judged on the pre-edge count, so a simultaneous pop does not make room
    assign push = i_rx_done && (count_q != FULL);

    // Occupancy update: push and pop on the same edge cancel out
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_idx_q <= wr_idx_q + 1'b1;
            end
            if (pop) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
            count_q <= count_d;
            if (i_rx_done && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Byte storage; contents are don't-care after reset because the pointers are cleared
    always_ff @(posedge i_wb_clk) begin
        if (push) begin
            mem_q[wr_idx_q] <= i_rx_dat;
        end
    end

    // Write sequencer: start only when the CPU is idle, never preempted once started
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ptr_d   = ptr_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !i_cpu_cyc) begin
                    state_d = S_WRITE;
                    cyc_d   = 1'b1;
                    adr_d   = ptr_q;
                    dat_d   = 32'(mem_q[rd_idx_q]);
                end
            end
            S_WRITE: begin
                if (i_wb_ack) begin
                    pop     = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = S_IDLE;
                    ptr_d   = (ptr_q == ADR_UL) ? ADR_LL : ptr_q + 32'd4;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers; reset abandons any in-flight write
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            ptr_q   <= ADR_LL;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_wb_sel   = {4{cyc_q}};
    assign o_wb_we    = cyc_q;
    assign o_wb_cyc   = cyc_q;
    assign o_grant    = cyc_q;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ble_rx_queue.sv
// Bench for ble_rx_queue: scoreboard of expected RAM writes plus cycle-level checks.
// RAM model acks one cycle after cyc is seen, like servant_ram.
// CPU cyc held high in some scenarios to exercise arbitration and overflow.
module tb_ble_rx_queue;

    localparam logic [31:0] ADR_LL = 32'h730;
    localparam logic [31:0] ADR_UL = 32'h1FFC;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_dat = 8'h00;
    logic        rx_done = 1'b0;
    logic        cpu_cyc = 1'b0;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack = 1'b0;
    logic        grant;
    logic [4:0]  count;
    logic        overflow;

    int          vectors = 0;
    int          miscompares = 0;
    wr_t         exp_q[$];
    logic [31:0] obs_adr[$];
    logic [31:0] model_ptr = ADR_LL;
    wr_t         mon_e;

    ble_rx_queue dut (
        .i_wb_clk   (clk),
        .i_wb_rst   (rst),
        .i_rx_dat   (rx_dat),
        .i_rx_done  (rx_done),
        .i_cpu_cyc  (cpu_cyc),
        .o_wb_adr   (wb_adr),
        .o_wb_dat   (wb_dat),
        .o_wb_sel   (wb_sel),
        .o_wb_we    (wb_we),
        .o_wb_cyc   (wb_cyc),
        .i_wb_ack   (wb_ack),
        .o_grant    (grant),
        .o_count    (count),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    // RAM model: single-cycle ack, deasserted the cycle after
    always @(posedge clk) wb_ack <= wb_cyc & ~wb_ack;

    task automatic push_byte(input logic [7:0] b, input bit accept);
        wr_t e;
        rx_dat  = b;
        rx_done = 1'b1;
        if (accept) begin
            e.adr = model_ptr;
            e.dat = {24'h0, b};
            exp_q.push_back(e);
            model_ptr = (model_ptr == ADR_UL) ? ADR_LL : model_ptr + 32'd4;
        end
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (count == 5'd0 && !wb_cyc) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rx_done = 1'b0; cpu_cyc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({wb_cyc, wb_we, grant, wb_sel} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_bus got cyc=%b we=%b grant=%b sel=%h exp all 0", wb_cyc, wb_we, grant, wb_sel);
        end
        vectors++;
        if (count !== 5'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fifo got count=%0d ovf=%b exp 0/0", count, overflow);
        end
        rst = 1'b0;
        exp_q.delete();
        model_ptr = ADR_LL;
        @(negedge clk);
    endtask

    task automatic test_single();
        push_byte(8'hA5, 1'b1);
        vectors++;
        if (count !== 5'd1 || wb_cyc !== 1'b0) begin
            miscompares++;
            $display("FAIL single_c1 got count=%0d cyc=%b exp 1/0", count, wb_cyc);
        end
        @(negedge clk);
        vectors++;
        if (wb_cyc !== 1'b1 || grant !== 1'b1 || wb_adr !== 32'h730 || wb_dat !== 32'hA5 || wb_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL single_c2 got cyc=%b grant=%b adr=%h dat=%h sel=%h exp 1/1/730/a5/f",
                     wb_cyc, grant, wb_adr, wb_dat, wb_sel);
        end
        @(negedge clk);
        vectors++;
        if (wb_cyc !== 1'b1 || wb_adr !== 32'h730) begin
            miscompares++;
            $display("FAIL single_c3 got cyc=%b adr=%h exp 1/730", wb_cyc, wb_adr);
        end
        @(negedge clk);
        vectors++;
        if (wb_cyc !== 1'b0 || grant !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL single_c4 got cyc=%b grant=%b count=%0d exp 0/0/0", wb_cyc, grant, count);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_sb got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_three();
        bit ok;
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        drain(100, ok);
        vectors++;
        if (!ok || exp_q.size() != 0 || count !== 5'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL three_drain got ok=%b pending=%0d count=%0d ovf=%b exp 1/0/0/0",
                     ok, exp_q.size(), count, overflow);
        end
    endtask

    task automatic test_cpu_hold();
        cpu_cyc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h10 + 8'(i), 1'b1);
            vectors++;
            if (wb_cyc !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_nocyc got cyc=%b exp 0 at push %0d", wb_cyc, i);
            end
        end
        vectors++;
        if (count !== 5'd5) begin
            miscompares++;
            $display("FAIL hold_count got %0d exp 5", count);
        end
        cpu_cyc = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vectors++;
            if (wb_cyc !== ((i % 3) != 2)) begin
                miscompares++;
                $display("FAIL hold_pattern got cyc=%b exp %b at cycle %0d", wb_cyc, ((i % 3) != 2), i);
            end
        end
        vectors++;
        if (count !== 5'd0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL hold_drain got count=%0d pending=%0d exp 0/0", count, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        cpu_cyc = 1'b1;
        for (int i = 0; i < 18; i++) begin
            push_byte(8'h40 + 8'(i), i < 16);
            vectors++;
            if (wb_cyc !== 1'b0) begin
                miscompares++;
                $display("FAIL ovf_nocyc got cyc=%b exp 0 at push %0d", wb_cyc, i);
            end
        end
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_full got count=%0d ovf=%b exp 16/1", count, overflow);
        end
        cpu_cyc = 1'b0;
        drain(200, ok);
        vectors++;
        if (!ok || exp_q.size() != 0 || count !== 5'd0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drain got ok=%b pending=%0d count=%0d ovf=%b exp 1/0/0/1",
                     ok, exp_q.size(), count, overflow);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int remaining;
        remaining = 32'(ADR_UL - ADR_LL) / 4;
        while (remaining > 0) begin
            for (int i = 0; i < 8 && remaining > 0; i++) begin
                push_byte(8'(remaining), 1'b1);
                remaining--;
            end
            drain(100, ok);
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL wrap_advance got drain timeout, %0d left exp drained", remaining);
                break;
            end
        end
        obs_adr.delete();
        push_byte(8'hC1, 1'b1);
        push_byte(8'hC2, 1'b1);
        drain(100, ok);
        vectors++;
        if (!ok || obs_adr.size() != 2) begin
            miscompares++;
            $display("FAIL wrap_count got ok=%b writes=%0d exp 1/2", ok, obs_adr.size());
        end else begin
            vectors++;
            if (obs_adr[0] !== 32'h1FFC || obs_adr[1] !== 32'h730) begin
                miscompares++;
                $display("FAIL wrap_adr got %h,%h exp 1ffc,730", obs_adr[0], obs_adr[1]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        push_byte(8'h77, 1'b1);
        @(negedge clk);
        vectors++;
        if (wb_cyc !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_start got cyc=%b exp 1", wb_cyc);
        end
        rst = 1'b1;
        exp_q.delete();
        model_ptr = ADR_LL;
        @(negedge clk);
        vectors++;
        if (wb_cyc !== 1'b0 || grant !== 1'b0 || count !== 5'd0) begin
            miscompares++;
            $display("FAIL midrst_clear got cyc=%b grant=%b count=%0d exp 0/0/0", wb_cyc, grant, count);
        end
        rst = 1'b0;
        @(negedge clk);
        obs_adr.delete();
        push_byte(8'h5A, 1'b1);
        drain(100, ok);
        vectors++;
        if (!ok || obs_adr.size() != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_next got ok=%b writes=%0d pending=%0d exp 1/1/0", ok, obs_adr.size(), exp_q.size());
        end else begin
            vectors++;
            if (obs_adr[0] !== 32'h730) begin
                miscompares++;
                $display("FAIL midrst_adr got %h exp 730", obs_adr[0]);
            end
        end
    endtask

    initial begin
        // Write monitor: a write completes on the edge after cyc&ack is seen
        fork
            forever begin
                @(negedge clk);
                if (wb_cyc && wb_ack && !rst) begin
                    vectors++;
                    obs_adr.push_back(wb_adr);
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL wr_unexpected got adr=%h dat=%h exp no write", wb_adr, wb_dat);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (wb_adr !== mon_e.adr || wb_dat !== mon_e.dat || wb_sel !== 4'hF ||
                            wb_we !== 1'b1 || grant !== 1'b1) begin
                            miscompares++;
                            $display("FAIL wr_data got adr=%h dat=%h sel=%h we=%b grant=%b exp adr=%h dat=%h sel=f we=1 grant=1",
                                     wb_adr, wb_dat, wb_sel, wb_we, grant, mon_e.adr, mon_e.dat);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single();
        test_three();
        test_cpu_hold();
        test_overflow();
        test_reset();
        test_wrap();
        test_reset_mid_write();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
